// File: rtl/pair_dist_engine.sv
`default_nettype none
// ============================================================================
// Module   : pair_dist_engine
// Purpose  : Min/max pairwise distance responder. When start goes low, it
//            loads NUM_VALS signed 16-bit operands from byte-wide data
//            memory. It then scans every unordered pair (j<k) for |a-b| and
//            writes the min and max distance back to memory (high byte
//            first). Completion is acknowledged on done.
// Ports    : clk, rst_n        clock, async active-low reset
//            start            active-low request (1 = arm, 0 = run)
//            done             high once results are in memory
//            mem_addr/mem_rd_data/mem_wr_en/mem_wr_data
//                             shared single-port data memory (sync read)
//            min_dist/max_dist, min_j/min_k, max_j/max_k
//                             last result and index pairs (debug)
// Revision : 1.0  initial release
// ============================================================================
module pair_dist_engine #(
   parameter int NUM_VALS = 32,
   parameter int MIN_ADDR = 66,
   parameter int MAX_ADDR = 68
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        done,
   output logic [7:0]  mem_addr,
   input  logic [7:0]  mem_rd_data,
   output logic        mem_wr_en,
   output logic [7:0]  mem_wr_data,
   output logic [15:0] min_dist,
   output logic [15:0] max_dist,
   output logic [4:0]  min_j,
   output logic [4:0]  min_k,
   output logic [4:0]  max_j,
   output logic [4:0]  max_k
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPARE = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [6:0] c_load_last = 7'(2 * NUM_VALS);
   localparam logic [6:0] c_addr_last = 7'(2 * NUM_VALS - 1);
   localparam logic [4:0] c_k_last    = 5'(NUM_VALS - 1);
   localparam logic [4:0] c_j_last    = 5'(NUM_VALS - 2);
   localparam logic [7:0] c_min_hi    = 8'(MIN_ADDR);
   localparam logic [7:0] c_min_lo    = 8'(MIN_ADDR + 1);
   localparam logic [7:0] c_max_hi    = 8'(MAX_ADDR);
   localparam logic [7:0] c_max_lo    = 8'(MAX_ADDR + 1);

   state_t      r_state;
   logic        r_armed;
   logic [6:0]  r_cnt;
   logic [4:0]  r_j;
   logic [4:0]  r_k;
   logic [1:0]  r_wsub;
   logic [15:0] r_vals [0:31];

   logic [15:0] w_a;
   logic [15:0] w_b;
   logic [16:0] w_diff;
   logic [15:0] w_dist;
   logic        w_first;
   logic        w_min_upd;
   logic        w_max_upd;
   logic [15:0] w_min_nxt;
   logic        w_pair_last;
   logic        w_scan_end;
   logic [5:0]  w_byte;

   assign w_a    = r_vals[r_j];
   assign w_b    = r_vals[r_k];
   assign w_diff = {w_a[15], w_a} - {w_b[15], w_b};
   // Negation modulo 2^16 keeps the exact 65535 case intact.
   assign w_dist = w_diff[16] ? (16'd0 - w_diff[15:0]) : w_diff[15:0];

   // The first pair always seeds both results so that an all-equal operand
   // set still reports (0,1) for the max pair rather than the init indices.
   assign w_first     = (r_j == 5'd0) && (r_k == 5'd1);
   assign w_min_upd   = w_first || (w_dist < min_dist);
   assign w_max_upd   = w_first || (w_dist > max_dist);
   assign w_min_nxt   = w_min_upd ? w_dist : min_dist;
   assign w_pair_last = (r_k == c_k_last);
   assign w_scan_end  = w_pair_last && (r_j == c_j_last);

   // Read data trails the address by one cycle, so count c captures byte c-1.
   assign w_byte = 6'(r_cnt - 7'd1);

   always_ff @(posedge clk) begin
      if (r_state == S_LOAD && r_cnt != 7'd0) begin
         if (w_byte[0])
            r_vals[w_byte[5:1]][7:0]  <= mem_rd_data;
         else
            r_vals[w_byte[5:1]][15:8] <= mem_rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_armed     <= 1'b0;
         r_cnt       <= 7'd0;
         r_j         <= 5'd0;
         r_k         <= 5'd0;
         r_wsub      <= 2'd0;
         done        <= 1'b0;
         mem_addr    <= 8'd0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= 8'd0;
         min_dist    <= 16'hFFFF;
         max_dist    <= 16'd0;
         min_j       <= 5'd0;
         min_k       <= 5'd0;
         max_j       <= 5'd0;
         max_k       <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_state  <= S_LOAD;
                  r_armed  <= 1'b0;
                  r_cnt    <= 7'd0;
                  mem_addr <= 8'd0;
                  min_dist <= 16'hFFFF;
                  max_dist <= 16'd0;
                  min_j    <= 5'd0;
                  min_k    <= 5'd0;
                  max_j    <= 5'd0;
                  max_k    <= 5'd0;
               end
            end

            S_LOAD: begin
               if (r_cnt < c_addr_last)
                  mem_addr <= mem_addr + 8'd1;
               if (r_cnt == c_load_last) begin
                  r_state <= S_COMPARE;
                  r_j     <= 5'd0;
                  r_k     <= 5'd1;
               end else begin
                  r_cnt <= r_cnt + 7'd1;
               end
            end

            S_COMPARE: begin
               if (w_min_upd) begin
                  min_dist <= w_dist;
                  min_j    <= r_j;
                  min_k    <= r_k;
               end
               if (w_max_upd) begin
                  max_dist <= w_dist;
                  max_j    <= r_j;
                  max_k    <= r_k;
               end
               if (w_scan_end) begin
                  // First write is launched here, so it must see this
                  // cycle's final minimum.
                  r_state     <= S_WRITE;
                  r_wsub      <= 2'd0;
                  mem_wr_en   <= 1'b1;
                  mem_addr    <= c_min_hi;
                  mem_wr_data <= w_min_nxt[15:8];
               end else if (w_pair_last) begin
                  r_j <= r_j + 5'd1;
                  r_k <= r_j + 5'd2;
               end else begin
                  r_k <= r_k + 5'd1;
               end
            end

            S_WRITE: begin
               r_wsub <= r_wsub + 2'd1;
               case (r_wsub)
                  2'd0: begin
                     mem_addr    <= c_min_lo;
                     mem_wr_data <= min_dist[7:0];
                  end
                  2'd1: begin
                     mem_addr    <= c_max_hi;
                     mem_wr_data <= max_dist[15:8];
                  end
                  2'd2: begin
                     mem_addr    <= c_max_lo;
                     mem_wr_data <= max_dist[7:0];
                  end
                  default: begin
                     mem_wr_en <= 1'b0;
                     done      <= 1'b1;
                     r_state   <= S_DONE;
                  end
               endcase
            end

            S_DONE: begin
               if (start) begin
                  r_state <= S_IDLE;
                  done    <= 1'b0;
                  r_armed <= 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pair_dist_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pair_dist_engine
// Purpose  : Directed bench for pair_dist_engine. Drives one 32-operand
//            instance and one 2-operand instance, each with its own
//            byte-wide synchronous-read memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_pair_dist_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 32-operand instance
   logic        start, done, mem_wr_en;
   logic [7:0]  mem_addr, mem_rd_data, mem_wr_data;
   logic [15:0] min_dist, max_dist;
   logic [4:0]  min_j, min_k, max_j, max_k;

   // 2-operand instance
   logic        start2, done2, mem_wr_en2;
   logic [7:0]  mem_addr2, mem_rd_data2, mem_wr_data2;
   logic [15:0] min_dist2, max_dist2;
   logic [4:0]  min_j2, min_k2, max_j2, max_k2;

   pair_dist_engine #(.NUM_VALS(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .min_dist(min_dist), .max_dist(max_dist),
      .min_j(min_j), .min_k(min_k), .max_j(max_j), .max_k(max_k)
   );

   pair_dist_engine #(.NUM_VALS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .done(done2),
      .mem_addr(mem_addr2), .mem_rd_data(mem_rd_data2),
      .mem_wr_en(mem_wr_en2), .mem_wr_data(mem_wr_data2),
      .min_dist(min_dist2), .max_dist(max_dist2),
      .min_j(min_j2), .min_k(min_k2), .max_j(max_j2), .max_k(max_k2)
   );

   // Memories; the bench loader port takes priority over DUT writes.
   logic [7:0] mem  [0:255];
   logic [7:0] mem2 [0:255];
   logic       ld_we = 1'b0;
   logic       ld_sel = 1'b0;
   logic [7:0] ld_addr = 8'd0;
   logic [7:0] ld_wd = 8'd0;
   int         wr_cnt = 0;
   int         bad_wr = 0;

   always @(posedge clk) begin
      if (ld_we && !ld_sel)
         mem[ld_addr] <= ld_wd;
      else if (mem_wr_en) begin
         mem[mem_addr] <= mem_wr_data;
         wr_cnt <= wr_cnt + 1;
         if (mem_addr < 8'd66 || mem_addr > 8'd69)
            bad_wr <= bad_wr + 1;
      end
      mem_rd_data <= mem[mem_addr];
   end

   always @(posedge clk) begin
      if (ld_we && ld_sel)
         mem2[ld_addr] <= ld_wd;
      else if (mem_wr_en2)
         mem2[mem_addr2] <= mem_wr_data2;
      mem_rd_data2 <= mem2[mem_addr2];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_byte(input logic sel, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_we = 1'b1; ld_sel = sel; ld_addr = a; ld_wd = d;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   task automatic load_val(input logic sel, input int i, input logic [15:0] v);
      load_byte(sel, 8'(2 * i), v[15:8]);
      load_byte(sel, 8'(2 * i + 1), v[7:0]);
   endtask

   // Arms with start=1, drops start at a negedge; the following posedge is E.
   task automatic do_run(input logic use2, input int lat, input string tag);
      @(negedge clk);
      if (use2) start2 = 1'b1; else start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (use2) start2 = 1'b0; else start = 1'b0;
      @(posedge clk);
      repeat (lat - 1) @(posedge clk);
      #1 chk({tag, " done_early"}, 32'(use2 ? done2 : done), 32'd0);
      @(posedge clk);
      #1 chk({tag, " done"}, 32'(use2 ? done2 : done), 32'd1);
   endtask

   task automatic chk_res(input string tag, input logic [15:0] emin, input logic [15:0] emax,
                          input int mj, input int mk, input int xj, input int xk);
      chk({tag, " core66_67"}, {16'd0, mem[66], mem[67]}, {16'd0, emin});
      chk({tag, " core68_69"}, {16'd0, mem[68], mem[69]}, {16'd0, emax});
      chk({tag, " min_dist"}, 32'(min_dist), 32'(emin));
      chk({tag, " max_dist"}, 32'(max_dist), 32'(emax));
      chk({tag, " min_pair"}, {22'd0, min_j, min_k}, 32'((mj << 5) | mk));
      chk({tag, " max_pair"}, {22'd0, max_j, max_k}, 32'((xj << 5) | xk));
   endtask

   task automatic load_set1();
      // i*7 with -32768 at 5 and 32767 at 20
      for (int i = 0; i < 32; i++) begin
         if (i == 5)       load_val(1'b0, i, 16'h8000);
         else if (i == 20) load_val(1'b0, i, 16'h7FFF);
         else              load_val(1'b0, i, 16'(i * 7));
      end
   endtask

   int saved_wr;

   initial begin
      rst_n = 1'b0; start = 1'b1; start2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst done", 32'(done), 32'd0);
      chk("rst wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst addr", 32'(mem_addr), 32'd0);
      chk("rst wr_data", 32'(mem_wr_data), 32'd0);
      chk("rst min", 32'(min_dist), 32'hFFFF);
      chk("rst max", 32'(max_dist), 32'd0);
      chk("rst idx", {12'd0, min_j, min_k, max_j, max_k}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sentinel bytes that must never be overwritten
      load_byte(1'b0, 8'd64, 8'hA5);
      load_byte(1'b0, 8'd65, 8'h5A);

      // Extremes: max 65535 at (5,20), min 7 at (0,1)
      load_set1();
      do_run(1'b0, 565, "ext");
      chk_res("ext", 16'd7, 16'hFFFF, 0, 1, 5, 20);

      // Descending 1000-3i, v[25]=970 duplicates v[10]: min 0 (10,25), max 93 (0,31)
      for (int i = 0; i < 32; i++)
         load_val(1'b0, i, (i == 25) ? 16'd970 : 16'(1000 - 3 * i));
      do_run(1'b0, 565, "dup");
      chk_res("dup", 16'd0, 16'd93, 10, 25, 0, 31);

      // All equal
      for (int i = 0; i < 32; i++)
         load_val(1'b0, i, 16'h1234);
      do_run(1'b0, 565, "eq");
      chk_res("eq", 16'd0, 16'd0, 0, 1, 0, 1);

      // Ten runs with a shrinking max: stale max would stick at a larger value
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 32; i++)
            load_val(1'b0, i, (i == 3) ? 16'(r * 100 + 10 - r) : 16'(r * 100));
         do_run(1'b0, 565, $sformatf("run%0d", r));
         chk_res($sformatf("run%0d", r), 16'd0, 16'(10 - r), 0, 1, 0, 3);
      end

      // Start held low after done: no retrigger
      saved_wr = wr_cnt;
      repeat (1000) @(posedge clk);
      #1;
      chk("hold done", 32'(done), 32'd1);
      chk("hold writes", 32'(wr_cnt), 32'(saved_wr));

      // Reset in the middle of COMPARE
      load_set1();
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      @(negedge clk); start = 1'b0;
      @(posedge clk);
      repeat (200) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid done", 32'(done), 32'd0);
      chk("mid wr_en", 32'(mem_wr_en), 32'd0);
      chk("mid min", 32'(min_dist), 32'hFFFF);
      chk("mid max", 32'(max_dist), 32'd0);
      chk("mid idx", {12'd0, min_j, min_k, max_j, max_k}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saved_wr = wr_cnt;
      repeat (20) @(posedge clk);
      #1;
      chk("norun done", 32'(done), 32'd0);
      chk("norun addr", 32'(mem_addr), 32'd0);
      chk("norun writes", 32'(wr_cnt), 32'(saved_wr));
      do_run(1'b0, 565, "rerun");
      chk_res("rerun", 16'd7, 16'hFFFF, 0, 1, 5, 20);

      // Two-operand build: 5 and -3
      load_val(1'b1, 0, 16'd5);
      load_val(1'b1, 1, 16'hFFFD);
      do_run(1'b1, 10, "n2");
      chk("n2 min", 32'(min_dist2), 32'd8);
      chk("n2 max", 32'(max_dist2), 32'd8);
      chk("n2 core", {mem2[66], mem2[67], mem2[68], mem2[69]}, 32'h0008_0008);

      chk("stray writes", 32'(bad_wr), 32'd0);
      chk("core64_65", {16'd0, mem[64], mem[65]}, 32'h0000_A55A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
